// File: rtl/pueo_thresh_pkg.sv
// Shared default widths, types and reset constant for the PUEO beam threshold stage.
package pueo_thresh_pkg;
   localparam int ENV_BITS_DEF    = 18;
   localparam int THRESH_BITS_DEF = 18;

   typedef logic [ENV_BITS_DEF-1:0]    env_t;
   typedef logic [THRESH_BITS_DEF-1:0] thresh_t;

   localparam thresh_t THRESH_RESET = '1;
endpackage

// File: rtl/pueo_thresh_beam.sv
// One beam: serial shadow chain, active thresholds, two-stage compare and rate scalers.
// Trigger stretching is compiled in when PUEO_TRIG_STRETCH_EN is defined.
module pueo_thresh_beam
   import pueo_thresh_pkg::*;
#(
   parameter int NLEVELS      = 2,
   parameter int ENV_BITS     = ENV_BITS_DEF,
   parameter int THRESH_BITS  = THRESH_BITS_DEF,
   parameter int SCAL_BITS    = 16,
   parameter int TRIG_STRETCH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [THRESH_BITS-1:0]       thresh_i,
   input  logic                         thresh_wr_i,
   input  logic                         thresh_update_i,
   input  logic [ENV_BITS-1:0]          envelope_i,
   input  logic                         scaler_latch_i,
   output logic [NLEVELS-1:0]           trigger_o,
   output logic [NLEVELS*SCAL_BITS-1:0] scaler_o
);
   localparam logic [THRESH_BITS-1:0] THR_ONES = '1;
   localparam logic [SCAL_BITS-1:0]   SCAL_MAX = '1;

   if (THRESH_BITS != ENV_BITS || TRIG_STRETCH < 1) begin : g_bad_params
      $error("pueo_thresh_beam: THRESH_BITS must equal ENV_BITS and TRIG_STRETCH must be >= 1");
   end

   function automatic logic [SCAL_BITS-1:0] sat_inc(input logic [SCAL_BITS-1:0] v);
      return (v == SCAL_MAX) ? v : v + SCAL_BITS'(1);
   endfunction

   logic [THRESH_BITS-1:0] shadow_q [NLEVELS];
   logic [THRESH_BITS-1:0] active_q [NLEVELS];
   logic [THRESH_BITS-1:0] thr_p1_q [NLEVELS];
   logic [ENV_BITS-1:0]    env_p1_q;
   logic [NLEVELS-1:0]     hit_d, hit_q, rise;
   logic [SCAL_BITS-1:0]   live_q   [NLEVELS];
   logic [SCAL_BITS-1:0]   latched_q[NLEVELS];

   // Update copies the pre-shift shadow when it coincides with a write.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NLEVELS; k++) begin
            shadow_q[k] <= THR_ONES;
            active_q[k] <= THR_ONES;
         end
      end else begin
         if (thresh_wr_i) begin
            shadow_q[0] <= thresh_i;
            for (int k = 1; k < NLEVELS; k++) shadow_q[k] <= shadow_q[k-1];
         end
         if (thresh_update_i) begin
            for (int k = 0; k < NLEVELS; k++) active_q[k] <= shadow_q[k];
         end
      end
   end

   // Stage 1: envelope and the thresholds in force at this edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         env_p1_q <= '0;
         for (int k = 0; k < NLEVELS; k++) thr_p1_q[k] <= THR_ONES;
      end else begin
         env_p1_q <= envelope_i;
         for (int k = 0; k < NLEVELS; k++) thr_p1_q[k] <= active_q[k];
      end
   end

   always_comb begin
      hit_d = '0;
      for (int k = 0; k < NLEVELS; k++) hit_d[k] = (env_p1_q >= thr_p1_q[k]);
   end

   // Stage 2: registered hits; a rise is counted on the edge that raises hit_q.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) hit_q <= '0;
      else       hit_q <= hit_d;
   end

   assign rise = hit_d & ~hit_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NLEVELS; k++) begin
            live_q[k]    <= '0;
            latched_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NLEVELS; k++) begin
            if (scaler_latch_i) begin
               latched_q[k] <= live_q[k];
               live_q[k]    <= rise[k] ? SCAL_BITS'(1) : '0;
            end else if (rise[k]) begin
               live_q[k] <= sat_inc(live_q[k]);
            end
         end
      end
   end

   for (genvar k = 0; k < NLEVELS; k++) begin : g_pack
      assign scaler_o[k*SCAL_BITS +: SCAL_BITS] = latched_q[k];
   end

`ifdef PUEO_TRIG_STRETCH_EN
   localparam int               CNT_W      = $clog2(TRIG_STRETCH + 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TRIG_STRETCH - 1);

   logic [CNT_W-1:0] cnt_q [NLEVELS];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NLEVELS; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < NLEVELS; k++) begin
            if (hit_q[k])             cnt_q[k] <= CNT_RELOAD;
            else if (cnt_q[k] != '0)  cnt_q[k] <= cnt_q[k] - CNT_W'(1);
         end
      end
   end

   always_comb begin
      trigger_o = hit_q;
      for (int k = 0; k < NLEVELS; k++) begin
         if (cnt_q[k] != '0) trigger_o[k] = 1'b1;
      end
   end
`else
   assign trigger_o = hit_q;
`endif

endmodule

// File: rtl/pueo_beam_threshold_v3.sv
// NBEAMS x NLEVELS beam threshold stage with double-buffered thresholds and rate scalers.
// Optional trigger stretching is selected with the PUEO_TRIG_STRETCH_EN macro.
module pueo_beam_threshold_v3
   import pueo_thresh_pkg::*;
#(
   parameter int NBEAMS       = 2,
   parameter int NLEVELS      = 2,
   parameter int ENV_BITS     = ENV_BITS_DEF,
   parameter int THRESH_BITS  = THRESH_BITS_DEF,
   parameter int SCAL_BITS    = 16,
   parameter int TRIG_STRETCH = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NBEAMS*THRESH_BITS-1:0]       thresh_i,
   input  logic [NBEAMS-1:0]                   thresh_wr_i,
   input  logic [NBEAMS-1:0]                   thresh_update_i,
   input  logic [NBEAMS*ENV_BITS-1:0]          envelope_i,
   output logic [NBEAMS*NLEVELS-1:0]           trigger_o,
   input  logic                                scaler_latch_i,
   output logic [NBEAMS*NLEVELS*SCAL_BITS-1:0] scaler_o,
   output logic                                scaler_valid_o
);
   logic scaler_valid_q;

   // Valid rides one edge behind the latch strobe, alongside the new scaler_o.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) scaler_valid_q <= 1'b0;
      else       scaler_valid_q <= scaler_latch_i;
   end

   assign scaler_valid_o = scaler_valid_q;

   for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
      pueo_thresh_beam #(
         .NLEVELS      (NLEVELS),
         .ENV_BITS     (ENV_BITS),
         .THRESH_BITS  (THRESH_BITS),
         .SCAL_BITS    (SCAL_BITS),
         .TRIG_STRETCH (TRIG_STRETCH)
      ) u_beam (
         .clk_i           (clk_i),
         .rst_i           (rst_i),
         .thresh_i        (thresh_i[b*THRESH_BITS +: THRESH_BITS]),
         .thresh_wr_i     (thresh_wr_i[b]),
         .thresh_update_i (thresh_update_i[b]),
         .envelope_i      (envelope_i[b*ENV_BITS +: ENV_BITS]),
         .scaler_latch_i  (scaler_latch_i),
         .trigger_o       (trigger_o[b*NLEVELS +: NLEVELS]),
         .scaler_o        (scaler_o[b*NLEVELS*SCAL_BITS +: NLEVELS*SCAL_BITS])
      );
   end

endmodule

// File: doc/pueo_beam_threshold_v3.md
Name: pueo_beam_threshold_v3

Overview:
Parametrised successor to the dual-beam threshold stage. It compares NBEAMS beam envelopes against NLEVELS independently loaded thresholds per beam and produces per-beam, per-level trigger bits. Thresholds are double-buffered through serial shadow chains, and per-trigger rate scalers are added for threshold servoing. It sits directly after the envelope detectors and feeds the trigger combiner.

Parameters:
NBEAMS, 2, number of beams (1..48)
NLEVELS, 2, thresholds per beam (1..4)
ENV_BITS, 18, envelope input width (unsigned)
THRESH_BITS, 18, threshold width (unsigned, must equal ENV_BITS)
SCAL_BITS, 16, per-trigger scaler width
TRIG_STRETCH, 4, stretch length in clocks when PUEO_TRIG_STRETCH_EN is defined (>=1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
thresh_i  in  NBEAMS*THRESH_BITS  per-beam threshold write data; beam b at [b*THRESH_BITS +: THRESH_BITS]
thresh_wr_i  in  NBEAMS  per-beam shadow shift enable
thresh_update_i  in  NBEAMS  per-beam shadow-to-active copy strobe
envelope_i  in  NBEAMS*ENV_BITS  beam envelopes, one new value per clock
trigger_o  out  NBEAMS*NLEVELS  trigger bit for beam b, level l at index b*NLEVELS+l
scaler_latch_i  in  1  latch-and-clear strobe for all scalers
scaler_o  out  NBEAMS*NLEVELS*SCAL_BITS  latched counts, same indexing scaled by SCAL_BITS
scaler_valid_o  out  1  one-cycle pulse: scaler_o updated

Behaviour:
- Reset (async, any time): shadow and active thresholds all-ones; input registers, trigger_o, stretch counters, live scalers, scaler_o and scaler_valid_o are all 0. A reset mid-load discards partial shadow contents.
- Shadow load, per beam b, on a clock with thresh_wr_i[b]=1: shadow[b][0] <= thresh_i[b]; shadow[b][k] <= shadow[b][k-1]. The last level is written first. After NLEVELS writes, the first word written sits in level NLEVELS-1.
- Update: thresh_update_i[b]=1 sets active[b][*] <= shadow[b][*] in one clock.
  - If a write and an update to the same beam coincide, active takes the pre-shift shadow values; the shift still occurs.
  - Active values never change without an update strobe.
- Compare: envelope_i is registered (stage 1). Stage 2 computes hit[b][l] = (env_reg[b] >= active[b][l]), unsigned, registered.
  - Latency: envelope_i at clock N gives the trigger at clock N+2.
  - The active threshold in use is the value present at stage 1's clock edge.
  - A threshold of all-ones triggers only on an all-ones envelope.
- trigger_o = hit when stretch is compiled out.
- Scalers: one live SCAL_BITS counter per hit bit.
  - Increments on each rising edge of hit (0->1); a sustained hit counts once.
  - Saturates at 2^SCAL_BITS-1.
- Latch: on scaler_latch_i, scaler_o <= live counts. The live counters load 1 if a rising edge occurs that same cycle, else 0. scaler_valid_o pulses the next clock, coincident with the new scaler_o.
- A latch on consecutive cycles is legal; the second latch captures only the one-cycle interval.

Optional Feature:
Macro PUEO_TRIG_STRETCH_EN.
- Defined: each trigger_o bit has a down-counter.
  - When hit is 1, the counter reloads to TRIG_STRETCH-1 and trigger_o is 1.
  - trigger_o stays 1 while the counter is nonzero.
  - Retriggering during a stretch restarts the count.
  - Output latency is unchanged; minimum high time is TRIG_STRETCH clocks.
- Undefined: no counters are generated; trigger_o = hit.
- Scalers count raw hit edges in both builds.

Decomposition:
- Package pueo_thresh_pkg: ENV_BITS/THRESH_BITS defaults, typedef env_t, typedef thresh_t, and an all-ones constant THRESH_RESET.
- One sub-module, pueo_thresh_beam, is instantiated NBEAMS times. It holds one beam's shadow chain, active registers, compare pipeline, stretch logic and NLEVELS scalers.
- The top level handles scaler_valid_o and bus packing.

Test Plan:
- Reset, then envelope 0x3FFFF on all beams -> trigger_o all 1 two clocks later; envelope 0x3FFFE -> trigger_o 0.
- Beam0 writes 10 then 200, update one clock after the last write -> active[0][1]=10, active[0][0]=200. Envelope 150 -> trigger bit 1 high, bit 0 low, at N+2.
- Write and update on the same clock to a beam holding {5,7} -> active stays {5,7}, shadow shifts. A second update copies the new values.
- Envelope toggling 0/50 for 10 clocks, threshold 20, then latch -> scaler 5 and scaler_valid_o 1 one clock after the latch. With SCAL_BITS=3 and 10 edges -> 7 (saturated).
- Stretch build, TRIG_STRETCH=4, single-cycle hit -> trigger_o high for exactly 4 clocks. Hit repeated at offset 2 -> high for 6 clocks.
- Assert rst_i asynchronously mid-load and mid-stretch -> all outputs 0 immediately, active thresholds all-ones.
